// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the E stage / hazard unit and the iterative mul/div sequencer.
// The pipeline side uses the master modport; the sequencer uses the slave modport.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            startE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] srcaE;
    logic [XLEN-1:0] srcbE;
    logic [4:0]      rdE;
    logic            kill;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output startE, funct3E, srcaE, srcbE, rdE, kill,
        input  stall, done, result, rd_out
    );

    modport slave (
        input  startE, funct3E, srcaE, srcbE, rdE, kill,
        output stall, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: shift-add multiply and restoring divide, one bit per cycle,
// on magnitudes, with sign fix-up and result selection in a final FIX cycle.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} stateT;

    stateT             stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic [2:0]        opQ, opD;
    logic [4:0]        rdLatchQ, rdLatchD;
    logic [XLEN-1:0]   opndQ, opndD;
    logic [2*XLEN-1:0] accQ, accD;
    logic              negLoQ, negLoD;
    logic              negHiQ, negHiD;
    logic [XLEN-1:0]   resultQ, resultD;
    logic [4:0]        rdOutQ, rdOutD;

    logic              isDiv, aSigned, bSigned, signA, signB, divZero, divOvf;
    logic [XLEN-1:0]   absA, absB;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     remShift;
    logic              remGeq;
    logic [XLEN-1:0]   remSub;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   quoFix, remFix;

    always_comb begin
        isDiv   = bus.funct3E[2];
        aSigned = (bus.funct3E == 3'b001) || (bus.funct3E == 3'b010) ||
                  (bus.funct3E == 3'b100) || (bus.funct3E == 3'b110);
        bSigned = (bus.funct3E == 3'b001) || (bus.funct3E == 3'b100) ||
                  (bus.funct3E == 3'b110);
        signA   = aSigned && bus.srcaE[XLEN-1];
        signB   = bSigned && bus.srcbE[XLEN-1];
        absA    = signA ? -bus.srcaE : bus.srcaE;
        absB    = signB ? -bus.srcbE : bus.srcbE;
        divZero = isDiv && (bus.srcbE == '0);
        divOvf  = isDiv && !bus.funct3E[0] && (bus.srcaE == MinInt) && (&bus.srcbE);

        // Multiply: upper half accumulates, product shifts in from the top.
        mulSum   = {1'b0, accQ[2*XLEN-1:XLEN]} + (accQ[0] ? {1'b0, opndQ} : '0);
        // Divide: upper half is the partial remainder, lower half dividend -> quotient.
        remShift = {accQ[2*XLEN-1:XLEN], accQ[XLEN-1]};
        remGeq   = remShift >= {1'b0, opndQ};
        remSub   = XLEN'(remShift - {1'b0, opndQ});

        prodFix = negLoQ ? -accQ : accQ;
        quoFix  = negLoQ ? -accQ[XLEN-1:0] : accQ[XLEN-1:0];
        remFix  = negHiQ ? -accQ[2*XLEN-1:XLEN] : accQ[2*XLEN-1:XLEN];
    end

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        opD      = opQ;
        rdLatchD = rdLatchQ;
        opndD    = opndQ;
        accD     = accQ;
        negLoD   = negLoQ;
        negHiD   = negHiQ;
        resultD  = resultQ;
        rdOutD   = rdOutQ;

        if (bus.kill) begin
            stateD = StIdle;
        end else begin
            unique case (stateQ)
                StIdle: begin
                    if (bus.startE) begin
                        opD      = bus.funct3E;
                        rdLatchD = bus.rdE;
                        cntD     = '0;
                        stateD   = StRun;
                        negLoD   = signA ^ signB;
                        negHiD   = 1'b0;
                        // Special divides preload the final answer and skip RUN.
                        if (divZero) begin
                            accD   = {bus.srcaE, {XLEN{1'b1}}};
                            negLoD = 1'b0;
                            stateD = StFix;
                        end else if (divOvf) begin
                            accD   = {{XLEN{1'b0}}, MinInt};
                            negLoD = 1'b0;
                            stateD = StFix;
                        end else if (isDiv) begin
                            accD   = {{XLEN{1'b0}}, absA};
                            opndD  = absB;
                            negHiD = signA;
                        end else begin
                            accD  = {{XLEN{1'b0}}, absB};
                            opndD = absA;
                        end
                    end
                end
                StRun: begin
                    if (opQ[2]) begin
                        accD = {(remGeq ? remSub : remShift[XLEN-1:0]),
                                accQ[XLEN-2:0], remGeq};
                    end else begin
                        accD = {mulSum, accQ[XLEN-1:1]};
                    end
                    cntD = cntQ + CntW'(1);
                    if (cntQ == CntW'(XLEN - 1)) begin
                        stateD = StFix;
                    end
                end
                StFix: begin
                    if (opQ[2]) begin
                        resultD = opQ[1] ? remFix : quoFix;
                    end else begin
                        resultD = (opQ[1:0] == 2'b00) ? prodFix[XLEN-1:0]
                                                      : prodFix[2*XLEN-1:XLEN];
                    end
                    rdOutD = rdLatchQ;
                    stateD = StDone;
                end
                StDone: begin
                    stateD = StIdle;
                end
                default: begin
                    stateD = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            opQ      <= '0;
            rdLatchQ <= '0;
            opndQ    <= '0;
            accQ     <= '0;
            negLoQ   <= 1'b0;
            negHiQ   <= 1'b0;
            resultQ  <= '0;
            rdOutQ   <= '0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            opQ      <= opD;
            rdLatchQ <= rdLatchD;
            opndQ    <= opndD;
            accQ     <= accD;
            negLoQ   <= negLoD;
            negHiQ   <= negHiD;
            resultQ  <= resultD;
            rdOutQ   <= rdOutD;
        end
    end

    assign bus.stall  = ((stateQ == StIdle) && bus.startE && !bus.kill) ||
                        (stateQ == StRun) || (stateQ == StFix);
    assign bus.done   = (stateQ == StDone);
    assign bus.result = resultQ;
    assign bus.rd_out = rdOutQ;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: results, latency, stall, kill and async reset.
module tb_muldiv_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    muldiv_sequencer_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one op, then waits (bounded) for done. lat counts edges-after-start style cycles:
    // cycle 1 is the cycle following the start edge; lat=-1 means done never came.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int stl, output logic st0);
        @(posedge clk); #1;
        bus.startE  = 1'b1;
        bus.funct3E = f;
        bus.srcaE   = a;
        bus.srcbE   = b;
        bus.rdE     = rd;
        bus.kill    = 1'b0;
        #1 st0 = bus.stall;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        lat = -1;
        stl = 0;
        res = 'x;
        rdo = 'x;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                lat = c;
                res = bus.result;
                rdo = bus.rd_out;
                break;
            end
            if (bus.stall) stl++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.startE = 1'b0; bus.funct3E = '0; bus.srcaE = '0; bus.srcbE = '0;
        bus.rdE = '0; bus.kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        checks++; if (bus.rd_out !== 5'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", bus.rd_out); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [4:0] rdo; int lat, stl; logic st0;
        do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", r); end
        checks++; if (lat !== 34) begin failures++; $display("FAIL mul_latency got=%0d exp=34", lat); end
        checks++; if (st0 !== 1'b1) begin failures++; $display("FAIL mul_start_stall got=%b exp=1", st0); end
        checks++; if (stl !== 33) begin failures++; $display("FAIL mul_stall_cycles got=%0d exp=33", stl); end
        checks++; if (rdo !== 5'd5) begin failures++; $display("FAIL mul_rd got=%0d exp=5", rdo); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mul_done_pulse got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 32'hFFFFFFEB) begin failures++; $display("FAIL mul_hold got=%h exp=ffffffeb", bus.result); end
    endtask

    task automatic test_mulh();
        logic [31:0] r; logic [4:0] rdo; int lat, stl; logic st0;
        do_op(3'b001, 32'h80000000, 32'h80000000, 5'd6, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'h40000000) begin failures++; $display("FAIL mulh got=%h exp=40000000", r); end
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'hFFFFFFFE) begin failures++; $display("FAIL mulhu got=%h exp=fffffffe", r); end
        checks++; if (rdo !== 5'd7) begin failures++; $display("FAIL mulhu_rd got=%0d exp=7", rdo); end
        do_op(3'b010, 32'hFFFFFFFF, 32'd2, 5'd8, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", r); end
        do_op(3'b010, 32'd3, 32'hFFFFFFFF, 5'd8, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'h00000002) begin failures++; $display("FAIL mulhsu_bunsigned got=%h exp=00000002", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; logic [4:0] rdo; int lat, stl; logic st0;
        do_op(3'b101, 32'd100, 32'd7, 5'd9, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'd14) begin failures++; $display("FAIL divu got=%h exp=0000000e", r); end
        checks++; if (lat !== 34) begin failures++; $display("FAIL divu_latency got=%0d exp=34", lat); end
        do_op(3'b111, 32'd100, 32'd7, 5'd10, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL remu got=%h exp=00000002", r); end
        do_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd11, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg got=%h exp=fffffffd", r); end
        do_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd12, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL rem_neg got=%h exp=ffffffff", r); end
        do_op(3'b101, 32'hFFFFFFFF, 32'h80000000, 5'd13, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'd1) begin failures++; $display("FAIL divu_big got=%h exp=00000001", r); end
        do_op(3'b111, 32'hFFFFFFFF, 32'h80000000, 5'd13, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'h7FFFFFFF) begin failures++; $display("FAIL remu_big got=%h exp=7fffffff", r); end
    endtask

    task automatic test_special();
        logic [31:0] r; logic [4:0] rdo; int lat, stl; logic st0;
        do_op(3'b100, 32'd5, 32'd0, 5'd14, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'hFFFFFFFF) begin failures++; $display("FAIL div0 got=%h exp=ffffffff", r); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL div0_latency got=%0d exp=2", lat); end
        checks++; if (rdo !== 5'd14) begin failures++; $display("FAIL div0_rd got=%0d exp=14", rdo); end
        do_op(3'b110, 32'd5, 32'd0, 5'd15, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'd5) begin failures++; $display("FAIL rem0 got=%h exp=00000005", r); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL rem0_latency got=%0d exp=2", lat); end
        do_op(3'b110, 32'hFFFFFFFB, 32'd0, 5'd15, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'hFFFFFFFB) begin failures++; $display("FAIL rem0_neg got=%h exp=fffffffb", r); end
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'h80000000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", r); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL div_ovf_latency got=%0d exp=2", lat); end
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd17, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL rem_ovf_latency got=%0d exp=2", lat); end
        do_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd18, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'h0) begin failures++; $display("FAIL divu_noovf got=%h exp=00000000", r); end
        checks++; if (lat !== 34) begin failures++; $display("FAIL divu_noovf_latency got=%0d exp=34", lat); end
    endtask

    task automatic test_kill();
        logic [31:0] r; logic [4:0] rdo; int lat, stl; logic st0; int dn;
        do_op(3'b000, 32'd3, 32'd4, 5'd3, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'd12) begin failures++; $display("FAIL kill_pre got=%h exp=0000000c", r); end
        @(posedge clk); #1;
        bus.startE = 1'b1; bus.funct3E = 3'b101; bus.srcaE = 32'd100; bus.srcbE = 32'd7;
        bus.rdE = 5'd9;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL kill_stall got=%b exp=0", bus.stall); end
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) dn++;
            @(posedge clk); #1;
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL kill_no_done got=%0d exp=0", dn); end
        checks++; if (bus.result !== 32'd12) begin failures++; $display("FAIL kill_result_hold got=%h exp=0000000c", bus.result); end
        checks++; if (bus.rd_out !== 5'd3) begin failures++; $display("FAIL kill_rd_hold got=%0d exp=3", bus.rd_out); end
        do_op(3'b111, 32'd100, 32'd7, 5'd4, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL kill_restart got=%h exp=00000002", r); end
        checks++; if (lat !== 34) begin failures++; $display("FAIL kill_restart_latency got=%0d exp=34", lat); end
        checks++; if (rdo !== 5'd4) begin failures++; $display("FAIL kill_restart_rd got=%0d exp=4", rdo); end
        // kill and startE together in IDLE: kill wins.
        @(posedge clk); #1;
        bus.startE = 1'b1; bus.kill = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL kill_start_stall got=%b exp=0", bus.stall); end
        @(posedge clk); #1;
        bus.startE = 1'b0; bus.kill = 1'b0;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL kill_start_idle got=%b exp=0", bus.stall); end
        // kill during DONE: done still pulses.
        do_op(3'b000, 32'd2, 32'd3, 5'd7, r, rdo, lat, stl, st0);
        bus.kill = 1'b1;
        #1;
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL kill_in_done got=%b exp=1", bus.done); end
        checks++; if (bus.result !== 32'd6) begin failures++; $display("FAIL kill_in_done_result got=%h exp=00000006", bus.result); end
        @(posedge clk); #1;
        bus.kill = 1'b0;
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL kill_after_done got=%b exp=0", bus.done); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [4:0] rdo; int lat, stl; logic st0;
        do_op(3'b101, 32'd50, 32'd5, 5'd20, r, rdo, lat, stl, st0);
        checks++; if (r !== 32'd10) begin failures++; $display("FAIL b2b_first got=%h exp=0000000a", r); end
        // New op presented while in DONE must wait for IDLE.
        bus.startE = 1'b1; bus.funct3E = 3'b011; bus.srcaE = 32'h00010000;
        bus.srcbE = 32'h00010000; bus.rdE = 5'd21;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL b2b_done_stall got=%b exp=0", bus.stall); end
        @(posedge clk); #1;
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL b2b_idle_stall got=%b exp=1", bus.stall); end
        @(posedge clk); #1;
        bus.startE = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin lat = c; break; end
            @(posedge clk); #1;
        end
        checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        checks++; if (bus.result !== 32'd1) begin failures++; $display("FAIL b2b_result got=%h exp=00000001", bus.result); end
        checks++; if (bus.rd_out !== 5'd21) begin failures++; $display("FAIL b2b_rd got=%0d exp=21", bus.rd_out); end
    endtask

    task automatic test_async_reset();
        int dn;
        @(posedge clk); #1;
        bus.startE = 1'b1; bus.funct3E = 3'b000; bus.srcaE = 32'd9; bus.srcbE = 32'd9;
        bus.rdE = 5'd22;
        @(posedge clk); #1;
        bus.startE = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL areset_running got=%b exp=1", bus.stall); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL areset_stall got=%b exp=0", bus.stall); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL areset_done got=%b exp=0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL areset_result got=%h exp=0", bus.result); end
        checks++; if (bus.rd_out !== 5'h0) begin failures++; $display("FAIL areset_rd got=%h exp=0", bus.rd_out); end
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.stall) dn++;
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL areset_idle got=%0d exp=0", dn); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_kill();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
